match_ctrl: RTL

Match sequencer for the two-player pong game. It sits between the debounced buttons and `pong_graph`, and drives the graph's freeze control and ball re-serve. It also keeps the BCD scores shown by `text_graph`. It runs the serve countdown, point scoring, win detection and game-over hold, replacing the three-state new/play/over loop in `top`.

---
 rtl/match_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/match_ctrl.sv
// match_ctrl: match sequencer for two-player pong.
// Runs serve countdown, point scoring, win detection and the game-over hold,
// and keeps both BCD scores for the text overlay.
module match_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_CYCLES = 50_000_000,
  parameter int OVER_CYCLES  = 150_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       graph_still,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [7:0] left_score,
  output logic [7:0] right_score,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] phase
);

  localparam int MAX_CYC = (SERVE_CYCLES > OVER_CYCLES) ? SERVE_CYCLES : OVER_CYCLES;
  localparam int CW_RAW  = $clog2(MAX_CYC);
  localparam int CW      = (CW_RAW < 28) ? 28 : CW_RAW;

  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_CYCLES - 1);
  localparam logic [CW-1:0] OVER_LAST  = CW'(OVER_CYCLES - 1);
  localparam logic [7:0]    WIN_BCD    = 8'((WIN_SCORE / 10) * 16 + (WIN_SCORE % 10));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic          start_q;
  logic          start_rise;
  logic [CW-1:0] cnt;
  logic [7:0]    scored;

  // BCD +1 with saturation at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Reset asserts immediately, releases two clocks after the pin goes high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n      = rst_sync[1];
  assign start_rise = start & ~start_q;

  // Score of whichever side just scored; serve goes toward the conceding side
  assign scored = serve_dir ? left_score : right_score;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_rise) state_next = SERVE;
      SERVE:   if (cnt == SERVE_LAST) state_next = PLAY;
      PLAY:    if (miss_left || miss_right) state_next = POINT;
      POINT:   state_next = (scored == WIN_BCD) ? OVER : SERVE;
      OVER:    if (cnt == OVER_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: counter, serve pulse, scores, direction, winner, start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      cnt         <= '0;
      ball_reset  <= 1'b0;
      serve_dir   <= 1'b0;
      left_score  <= 8'h00;
      right_score <= 8'h00;
      winner      <= 1'b0;
    end else begin
      start_q    <= start;
      ball_reset <= (state_next == SERVE) && (state != SERVE);

      // Counter runs only while dwelling in a timed state, zero on entry
      if ((state_next != state) || !((state == SERVE) || (state == OVER)))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state == IDLE && start_rise) begin
        left_score  <= 8'h00;
        right_score <= 8'h00;
        serve_dir   <= 1'b0;
        winner      <= 1'b0;
      end

      // miss_left has priority when both arrive together
      if (state == PLAY) begin
        if (miss_left) begin
          right_score <= bcd_inc(right_score);
          serve_dir   <= 1'b0;
        end else if (miss_right) begin
          left_score  <= bcd_inc(left_score);
          serve_dir   <= 1'b1;
        end
      end

      if (state == POINT && state_next == OVER)
        winner <= ~serve_dir;
    end
  end

  assign graph_still = (state != PLAY);
  assign game_over   = (state == OVER);
  assign phase       = state;

endmodule
